// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit with HI/LO registers (EX stage).
//
// Runs mult/multu/div/divu/mthi/mtlo on the forwarded rs/rt operands. The
// result of a multiply or divide is computed at the launch edge and held in
// pending registers. It is committed to HI/LO when the Busy countdown expires.
//
// Optional feature macro: MD_MADD_EN
//   When defined, MDOp 110 (madd) and 111 (msub) accumulate the signed
//   product into {HI,LO}. When undefined, those opcodes are ignored.
//
// Parameters:
//   MULT_CYCLES  Busy duration for mult/multu/madd/msub (>=1)
//   DIV_CYCLES   Busy duration for div/divu (>=1)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   Start  in   launch MDOp this cycle (one-cycle pulse)
//   MDOp   in   [2:0] 000 mult, 001 multu, 010 div, 011 divu,
//                     100 mthi, 101 mtlo, 110 madd, 111 msub
//   A      in   [31:0] rs operand
//   B      in   [31:0] rt operand
//   Busy   out  operation in progress
//   HI     out  [31:0] HI register
//   LO     out  [31:0] LO register
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } md_op_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [63:0]      pend_val;
    logic             pend_wr;

    md_op_t           op;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_signed;
    logic [31:0]      a_mag;
    logic [31:0]      b_mag;
    logic [31:0]      div_den;
    logic [31:0]      q_mag;
    logic [31:0]      r_mag;
    logic [31:0]      div_q;
    logic [31:0]      div_r;

    logic             launch_busy;
    logic             launch_wr;
    logic [63:0]      launch_val;
    logic [CNT_W-1:0] launch_cnt;

    assign op = md_op_t'(MDOp);

    // Products and quotient/remainder from the current operands.
    // Signed division works on magnitudes and then restores signs, which
    // makes 0x80000000 / -1 wrap to 0x80000000 with no overflow trap.
    always_comb begin
        prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u     = {32'd0, A} * {32'd0, B};
        div_signed = (op == OP_DIV);
        a_mag      = (div_signed && A[31]) ? (~A + 32'd1) : A;
        b_mag      = (div_signed && B[31]) ? (~B + 32'd1) : B;
        div_den    = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag      = a_mag / div_den;
        r_mag      = a_mag % div_den;
        div_q      = (div_signed && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
        div_r      = (div_signed && A[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    // Launch decode for the operations that use the countdown.
    always_comb begin
        launch_busy = 1'b0;
        launch_wr   = 1'b0;
        launch_val  = '0;
        launch_cnt  = '0;
        case (op)
            OP_MULT: begin
                launch_busy = 1'b1;
                launch_wr   = 1'b1;
                launch_val  = prod_s;
                launch_cnt  = MULT_LOAD;
            end
            OP_MULTU: begin
                launch_busy = 1'b1;
                launch_wr   = 1'b1;
                launch_val  = prod_u;
                launch_cnt  = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
                // A zero divisor still occupies the unit but commits nothing.
                launch_busy = 1'b1;
                launch_wr   = (B != '0);
                launch_val  = {div_r, div_q};
                launch_cnt  = DIV_LOAD;
            end
`ifdef MD_MADD_EN
            OP_MADD: begin
                launch_busy = 1'b1;
                launch_wr   = 1'b1;
                launch_val  = {HI, LO} + prod_s;
                launch_cnt  = MULT_LOAD;
            end
            OP_MSUB: begin
                launch_busy = 1'b1;
                launch_wr   = 1'b1;
                launch_val  = {HI, LO} - prod_s;
                launch_cnt  = MULT_LOAD;
            end
`endif
            default: begin
                launch_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            Busy     <= 1'b0;
            counter  <= '0;
            pend_val <= '0;
            pend_wr  <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (launch_busy) begin
                            pend_val <= launch_val;
                            pend_wr  <= launch_wr;
                            counter  <= launch_cnt;
                            Busy     <= 1'b1;
                            state    <= S_BUSY;
                        end else if (op == OP_MTHI) begin
                            HI <= A;
                        end else if (op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                S_BUSY: begin
                    // Start is deliberately not examined here.
                    if (counter == CNT_ONE) begin
                        if (pend_wr) begin
                            HI <= pend_val[63:32];
                            LO <= pend_val[31:0];
                        end
                        counter <= '0;
                        Busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        counter <= counter - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
